// File: rtl/window_collector_if.sv
// Bundle of the producer, consumer and read-port signals of window_collector.
//
// Handshake: window_ready is the valid qualifier for window_data. There is no
// backpressure. A word is taken when window_ready=1 and the fill bank is free;
// receive rises for one cycle, on the cycle after each taken word. A word
// presented while the fill bank is still full is dropped, and overflow is set.
// win_valid/win_bank name the oldest complete window. A win_release pulse
// frees that bank, and is ignored while win_valid=0.
interface window_collector_if;
    logic [31:0] window_data;
    logic        window_ready;
    logic        stream_done;
    logic        receive;
    logic        win_valid;
    logic        win_bank;
    logic        win_release;
    logic        rd_bank;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] win_count;
    logic        overflow;
    logic        frag_err;
    logic        all_done;

    modport master (
        output window_data, window_ready, stream_done, win_release, rd_bank, rd_addr,
        input  receive, win_valid, win_bank, rd_data, win_count, overflow, frag_err, all_done
    );

    modport slave (
        input  window_data, window_ready, stream_done, win_release, rd_bank, rd_addr,
        output receive, win_valid, win_bank, rd_data, win_count, overflow, frag_err, all_done
    );
endinterface

// File: rtl/window_collector.sv
// Ping-pong window collector. It captures WIN_WORDS-word windows into two
// banks. The oldest complete window is handed to a consumer, which releases
// it when done. Either bank can be read at any time through a registered
// read port.
module window_collector #(
    parameter int WIN_WORDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    window_collector_if.slave  bus,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_BANK = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(WIN_WORDS - 1);

    state_t      state;
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic        fb;
    logic        ob;
    logic [5:0]  wp;
    logic [15:0] win_count;
    logic        overflow;
    logic        frag_err;
    logic        receive;
    logic        all_done;
    logic [31:0] rd_data;
    logic [31:0] mem [2][WIN_WORDS];

    logic accept;
    logic drop;
    logic complete;
    logic release_ok;
    logic frag;

    // Per-cycle decisions: take or drop the word, complete a window, release
    // a bank, and work out the full flags that follow.
    always_comb begin
        accept     = bus.window_ready && !full[fb];
        drop       = bus.window_ready && full[fb];
        complete   = accept && (wp == LAST);
        release_ok = bus.win_release && full[ob];
        // If the word that completes a window arrives with stream_done, the
        // window is whole, so this is not a fragment.
        frag       = bus.stream_done && (wp != 6'd0) && !complete;
        full_nxt   = full;
        if (release_ok) full_nxt[ob] = 1'b0;
        if (complete)   full_nxt[fb] = 1'b1;
    end

    // Bank pointers, write pointer, full flags, counters and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            fb        <= 1'b0;
            ob        <= 1'b0;
            wp        <= 6'd0;
            win_count <= 16'd0;
            overflow  <= 1'b0;
            frag_err  <= 1'b0;
            receive   <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            full     <= full_nxt;
            receive  <= accept;
            all_done <= bus.stream_done;
            if (drop) overflow <= 1'b1;
            if (frag) frag_err <= 1'b1;
            if (release_ok) ob <= ~ob;
            if (complete) begin
                wp        <= 6'd0;
                fb        <= ~fb;
                win_count <= win_count + 16'd1;
            end else if (bus.stream_done) begin
                // Any partial window is thrown away.
                wp <= 6'd0;
            end else if (accept) begin
                wp <= wp + 6'd1;
            end
        end
    end

    // Control FSM. It tracks whether the collector is idle, filling, or
    // waiting for the consumer to free the next fill bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.stream_done) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.window_ready) state <= full[fb] ? WAIT_BANK : FILL;
                end
                FILL: begin
                    if (complete && full_nxt[~fb]) state <= WAIT_BANK;
                end
                WAIT_BANK: begin
                    if (!full_nxt[fb]) state <= FILL;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window storage. The contents are not reset; the full flags say what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[fb][wp] <= bus.window_data;
    end

    // Registered read port. A read that hits the word being written in the
    // same cycle returns the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'd0;
        end else begin
            rd_data <= mem[bus.rd_bank][bus.rd_addr];
        end
    end

    assign bus.receive   = receive;
    assign bus.win_valid = full[ob];
    assign bus.win_bank  = ob;
    assign bus.rd_data   = rd_data;
    assign bus.win_count = win_count;
    assign bus.overflow  = overflow;
    assign bus.frag_err  = frag_err;
    assign bus.all_done  = all_done;
    assign fsm_state     = state;

endmodule

// File: tb/tb_window_collector.sv
// Directed bench for window_collector. It checks window capture, bank
// ping-pong, overflow drops, fragment handling, release and completion in
// the same cycle, and reset.
module tb_window_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] fsm_state;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         nr;

    window_collector_if bus();

    window_collector #(.WIN_WORDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents n back-to-back words base, base+1, ... and counts the receive
    // pulses seen one cycle after each word.
    task automatic stream(input int n, input logic [31:0] base, input bit done_last,
                          output int nrecv);
        nrecv = 0;
        for (int i = 0; i < n; i++) begin
            bus.window_ready = 1'b1;
            bus.window_data  = base + 32'(i);
            bus.stream_done  = done_last && (i == n - 1);
            tick();
            if (bus.receive) nrecv++;
        end
        bus.window_ready = 1'b0;
        bus.stream_done  = 1'b0;
    endtask

    task automatic rd_check(input logic b, input logic [5:0] a, input logic [31:0] exp,
                            input string tag);
        bus.rd_bank = b;
        bus.rd_addr = a;
        tick();
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.window_data  = 32'd0;
        bus.window_ready = 1'b0;
        bus.stream_done  = 1'b0;
        bus.win_release  = 1'b0;
        bus.rd_bank      = 1'b0;
        bus.rd_addr      = 6'd0;
        repeat (3) tick();

        // Reset state
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_count", bus.win_count, 0);
        check("rst_receive",   bus.receive,   0);
        check("rst_rd_data",   bus.rd_data,   0);
        check("rst_state",     fsm_state,     0);
        rst_n = 1'b1;
        tick();

        // One full window of 0x00..0x3F
        stream(64, 32'h0, 1'b0, nr);
        check("w1_recv_count", nr, 64);
        check("w1_win_valid",  bus.win_valid, 1);
        check("w1_win_bank",   bus.win_bank,  0);
        check("w1_win_count",  bus.win_count, 1);
        tick();
        check("w1_recv_idle",  bus.receive, 0);
        rd_check(1'b0, 6'd5,  32'h5,  "w1_rd_addr5");
        rd_check(1'b0, 6'd63, 32'h3F, "w1_rd_addr63");

        // Second window fills bank 1; the third is dropped
        stream(64, 32'h40, 1'b0, nr);
        check("w2_recv_count", nr, 64);
        check("w2_win_count",  bus.win_count, 2);
        check("w2_no_ovf_yet", bus.overflow, 0);
        check("w2_wait_bank",  fsm_state, 2);
        stream(64, 32'h80, 1'b0, nr);
        check("w3_recv_none",  nr, 0);
        check("w3_overflow",   bus.overflow, 1);
        check("w3_win_count",  bus.win_count, 2);
        check("w3_win_bank",   bus.win_bank, 0);
        rd_check(1'b0, 6'd0,  32'h0,  "w3_bank0_intact");
        rd_check(1'b1, 6'd0,  32'h40, "w3_bank1_addr0");
        rd_check(1'b1, 6'd63, 32'h7F, "w3_bank1_addr63");

        // Release bank 0 while a word is presented: that word is still dropped
        bus.win_release  = 1'b1;
        bus.window_ready = 1'b1;
        bus.window_data  = 32'hDEAD;
        tick();
        bus.win_release  = 1'b0;
        check("rel1_drop",      bus.receive,   0);
        check("rel1_win_bank",  bus.win_bank,  1);
        check("rel1_win_valid", bus.win_valid, 1);
        bus.window_data  = 32'hBEEF;
        tick();
        bus.window_ready = 1'b0;
        check("rel1_accept_next", bus.receive, 1);
        bus.win_release = 1'b1;
        tick();
        bus.win_release = 1'b0;
        check("rel2_win_valid", bus.win_valid, 0);
        check("rel2_win_bank",  bus.win_bank,  0);
        bus.win_release = 1'b1;
        tick();
        bus.win_release = 1'b0;
        check("rel_empty_ignored", bus.win_bank, 0);

        // Partial window (BEEF + 10 words), then stream_done
        stream(10, 32'h100, 1'b0, nr);
        bus.stream_done = 1'b1;
        tick();
        bus.stream_done = 1'b0;
        check("frag_all_done", bus.all_done, 1);
        check("frag_err",      bus.frag_err, 1);
        check("frag_idle",     fsm_state,    0);
        tick();
        check("frag_all_done_pulse", bus.all_done, 0);
        stream(64, 32'h200, 1'b0, nr);
        check("w4_recv_count", nr, 64);
        check("w4_win_count",  bus.win_count, 3);
        check("w4_win_bank",   bus.win_bank,  0);
        rd_check(1'b0, 6'd0,  32'h200, "w4_restart_addr0");
        rd_check(1'b0, 6'd10, 32'h20A, "w4_addr10");

        // Bank 1 completes in the same cycle that bank 0 is released
        stream(63, 32'h300, 1'b0, nr);
        check("w5_recv_count", nr, 63);
        bus.window_ready = 1'b1;
        bus.window_data  = 32'h33F;
        bus.win_release  = 1'b1;
        tick();
        bus.window_ready = 1'b0;
        bus.win_release  = 1'b0;
        check("same_cyc_receive",   bus.receive,   1);
        check("same_cyc_win_valid", bus.win_valid, 1);
        check("same_cyc_win_bank",  bus.win_bank,  1);
        check("same_cyc_win_count", bus.win_count, 4);
        stream(1, 32'h400, 1'b0, nr);
        check("same_cyc_bank0_accepts", nr, 1);
        rd_check(1'b0, 6'd0,  32'h400, "same_cyc_bank0_addr0");
        rd_check(1'b1, 6'd63, 32'h33F, "same_cyc_bank1_addr63");

        // Reset in the middle of a window
        stream(30, 32'h500, 1'b0, nr);
        rst_n = 1'b0;
        #1;
        check("mid_rst_win_count", bus.win_count, 0);
        check("mid_rst_win_valid", bus.win_valid, 0);
        check("mid_rst_overflow",  bus.overflow,  0);
        check("mid_rst_frag_err",  bus.frag_err,  0);
        check("mid_rst_receive",   bus.receive,   0);
        check("mid_rst_rd_data",   bus.rd_data,   0);
        tick();
        rst_n = 1'b1;

        // Fresh window after reset, with stream_done on its completing word
        stream(64, 32'h600, 1'b1, nr);
        check("w6_recv_count", nr, 64);
        check("w6_all_done",   bus.all_done,  1);
        check("w6_no_frag",    bus.frag_err,  0);
        check("w6_win_count",  bus.win_count, 1);
        check("w6_win_bank",   bus.win_bank,  0);
        check("w6_win_valid",  bus.win_valid, 1);
        rd_check(1'b0, 6'd0,  32'h600, "w6_addr0");
        rd_check(1'b0, 6'd29, 32'h61D, "w6_addr29");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/window_collector.md
WINDOW_COLLECTOR -- requirements
Module: window_collector

Interface
REQ-001 Parameter WIN_WORDS, default 64, 32-bit words per window (16 rows x 4 words of 8-bit pixels).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 window_data  input  32  window word, 4 pixels, byte 0 = leftmost.
REQ-005 window_ready  input  1  window_data valid this cycle; one word per cycle while high.
REQ-006 stream_done  input  1  one-cycle pulse: producer finished the frame.
REQ-007 receive  output  1  registered acknowledge, high one cycle after each accepted word.
REQ-008 win_valid  output  1  at least one complete window is held.
REQ-009 win_bank  output  1  bank index of the oldest complete window.
REQ-010 win_release  input  1  consumer frees the bank at win_bank; ignored when win_valid=0.
REQ-011 rd_bank  input  1  read bank select.
REQ-012 rd_addr  input  6  read word address, row*4 + word.
REQ-013 rd_data  output  32  registered read data.
REQ-014 win_count  output  16  complete windows captured since reset; wraps modulo 2^16.
REQ-015 overflow  output  1  sticky: a word was dropped because no bank was free.
REQ-016 frag_err  output  1  sticky: stream_done arrived with a partial window.
REQ-017 all_done  output  1  one-cycle pulse marking frame end.

Function
REQ-018 Storage: two banks (ping-pong) of WIN_WORDS x 32 bits; per-bank full flag; fill-bank pointer fb; 6-bit write pointer wp; oldest-bank pointer ob.
REQ-019 FSM states: IDLE, FILL, WAIT_BANK.
- IDLE -> FILL on window_ready.
- FILL -> WAIT_BANK when a window completes and the other bank is full.
- WAIT_BANK -> FILL when bank fb becomes free.
REQ-020 Acceptance: a word is accepted when window_ready=1 and bank fb is not full.
- Write data to bank fb, address wp.
- Increment wp.
- receive=1 on the next cycle.
REQ-021 Drop: when window_ready=1 and bank fb is full (WAIT_BANK):
- Discard the word.
- Set overflow.
- Keep receive=0.
- Leave wp unchanged.
REQ-022 Completion: on acceptance with wp=WIN_WORDS-1:
- Set full[fb] at the next edge.
- Clear wp to 0.
- Toggle fb.
- Increment win_count.
REQ-023 win_valid=full[ob] and win_bank=ob; both are registered-state derived, so win_valid rises the cycle after the completing word is accepted.
REQ-024 win_release with win_valid=1 clears full[ob] and toggles ob at that edge.
REQ-025 Release and completion in the same cycle both take effect; with both banks previously full, win_valid stays 1 and win_bank points to the other bank.
REQ-026 If release frees bank fb while a word is presented in WAIT_BANK, that word is dropped; acceptance resumes on the following cycle.
REQ-027 Reads: rd_data = bank[rd_bank][rd_addr] one cycle after the address is presented, independent of full flags.
REQ-028 A read and a write to the same bank and address in one cycle return the old data.
REQ-029 stream_done with wp=0: all_done pulses on the next cycle.
REQ-030 stream_done with wp!=0:
- Discard the partial window and clear wp to 0.
- Set frag_err.
- all_done pulses on the next cycle.
- FSM goes to IDLE.
REQ-031 stream_done coincident with the completing word: the window completes normally and frag_err is not set.
REQ-032 Full banks are unaffected by stream_done.

Reset
REQ-033 On rst_n low, asynchronously clear:
- FSM to IDLE.
- fb, ob, wp, full flags, win_count.
- overflow, frag_err, receive, all_done, win_valid, rd_data.
- Bank contents are not reset.
REQ-034 Reset mid-window discards all captured data; the first word after reset is written to bank 0, address 0.

Verification
REQ-035 Stream words 0x00000000..0x0000003F back-to-back.
- 64 receive pulses, each one cycle after its word.
- win_valid=1, win_bank=0, win_count=1.
- Reading rd_bank=0 at addr 5 returns 0x00000005.
REQ-036 Stream 192 words, no release.
- Banks 0 and 1 fill; win_count=2.
- Words 129-192 are dropped and overflow=1.
- Bank 0 addr 0 still holds word 1.
REQ-037 Hold two full windows, pulse win_release.
- win_bank 0 -> 1 and win_valid stays 1.
- A second release gives win_valid=0.
REQ-038 Stream 10 words, then pulse stream_done.
- frag_err=1 and all_done pulses.
- The next word is written to bank 0 address 0.
REQ-039 Assert rst_n low after 30 words.
- All outputs return to 0.
- A subsequent 64-word stream yields win_count=1 and win_bank=0.
REQ-040 Same cycle: release of bank 0 and completion of bank 1.
- win_valid stays 1 with win_bank=1.
- fb=0, and the next window is accepted into bank 0.
